// File: rtl/mips_ifu_pkg.sv
// Shared encodings for the MIPS instruction fetch unit and the control unit.
// NPC_* next-PC select codes are fixed and shared with control; IFU_* are the
// fetch FSM states. sign_ext16 widens an immediate field to 32 bits.
package mips_ifu_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3,
    NPC_EXCEPT = 3'd4
  } npc_op_t;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_EXEC  = 2'd2
  } ifu_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_ifu_npc.sv
// mips_npc: next-PC computation from the presented instruction and npc_op.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: pc/instr/npc_op/jr_target in; next_pc and is_exc (redirect to
// EXC_VECTOR: EXCEPT, undefined codes 5-7, or misaligned JR target) out.
module mips_npc
  import mips_ifu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [2:0]  npc_op,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        is_exc
);

  logic [31:0] seq_pc;
  logic [31:0] imm_ext;
  logic [31:0] br_off;
  npc_op_t     op;

  // Opcode bits are not needed for target formation.
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    op      = npc_op_t'(npc_op);
    seq_pc  = pc + PC_STEP;
    imm_ext = sign_ext16(instr[15:0]);
    br_off  = {imm_ext[29:0], 2'b00};
    is_exc  = 1'b0;
    next_pc = seq_pc;
    case (op)
      NPC_PLUS4:  next_pc = seq_pc;
      NPC_BRANCH: next_pc = seq_pc + br_off;
      NPC_JUMP:   next_pc = {seq_pc[31:28], instr[25:0], 2'b00};
      NPC_JR: begin
        // A word-misaligned register target cannot be fetched: raise instead.
        if (jr_target[1:0] != 2'b00) is_exc = 1'b1;
        else                         next_pc = jr_target;
      end
      default:    is_exc = 1'b1;  // NPC_EXCEPT and the unused codes 5-7
    endcase
    if (is_exc) next_pc = EXC_VECTOR;
  end

endmodule

// File: rtl/mips_ifu.sv
// mips_ifu: PC/IR/EPC holder and IDLE->FETCH->EXEC sequencer for the multi-cycle core.
// Latency: min 2 cycles per instruction (FETCH with ready, then EXEC).
// Backpressure: FETCH waits on imem_ready with addr held; hold freezes EXEC.
// Ports: clk/rst; imem_req/imem_addr/imem_ready/imem_rdata fetch handshake;
// npc_op/jr_target/hold from control; instr/nop/pc/pc_plus4 to control and
// datapath; epc and the except_taken pulse for the exception path.
module mips_ifu
  import mips_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic [2:0]  npc_op,
  input  logic [31:0] jr_target,
  input  logic        hold,
  output logic [31:0] instr,
  output logic        nop,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        except_taken
);

  ifu_state_t  state, state_nxt;
  logic        latch_ir;
  logic        commit;
  logic [31:0] next_pc;
  logic        is_exc;

  mips_npc #(.EXC_VECTOR(EXC_VECTOR)) u_npc (
    .pc        (pc),
    .instr     (instr),
    .npc_op    (npc_op),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .is_exc    (is_exc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IFU_IDLE;
    else     state <= state_nxt;
  end

  // Outputs depend on state only, so npc_op never reaches an output
  // combinationally and there is no loop through control.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    nop       = 1'b1;
    latch_ir  = 1'b0;
    commit    = 1'b0;
    case (state)
      IFU_IDLE: state_nxt = IFU_FETCH;
      IFU_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          latch_ir  = 1'b1;
          state_nxt = IFU_EXEC;
        end
      end
      IFU_EXEC: begin
        nop = 1'b0;
        if (!hold) begin
          commit    = 1'b1;
          state_nxt = IFU_FETCH;
        end
      end
      default: state_nxt = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr        <= 32'd0;
      epc          <= 32'd0;
      except_taken <= 1'b0;
    end else begin
      except_taken <= 1'b0;
      if (latch_ir) instr <= imem_rdata;
      if (commit) begin
        pc <= next_pc;
        if (is_exc) begin
          epc          <= pc;
          except_taken <= 1'b1;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + PC_STEP;

endmodule

// File: doc/mips_ifu.md
Name: mips_ifu

Overview:
- Instruction fetch unit for the multi-cycle MIPS core.
- Holds the PC and fetches from instruction memory over a req/ready handshake.
- Latches the instruction and presents opcode/funct/rt plus a `nop` qualifier to the control unit.
- Consumes the control unit's `NPCOp` in the execute cycle to compute and commit the next PC, including the exception redirect and EPC capture.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on `NPC_EXCEPT`.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  32  fetch address, equals pc while imem_req=1
- imem_ready  in  1  rdata valid; request accepted this cycle
- imem_rdata  in  32  instruction word
- npc_op  in  3  next-PC select from control (NPC_* encoding)
- jr_target  in  32  rs register value for JR
- hold  in  1  freeze EXEC: no PC commit, instruction stays presented
- instr  out  32  latched instruction (opcode=[31:26], rt=[20:16], funct=[5:0])
- nop  out  1  1 = no valid instruction presented; drives control `nop`
- pc  out  32  address of the presented instruction
- pc_plus4  out  32  pc+4, for the jal link write (WDSel_FromPC)
- epc  out  32  PC of the last excepting instruction
- except_taken  out  1  one-cycle pulse when an exception redirect commits

Behaviour:
- Reset values (async, immediate): state=IDLE, pc=RESET_PC, instr=0, nop=1, imem_req=0, epc=0, except_taken=0.
- States:
  - IDLE: one cycle after reset release, then → FETCH.
  - FETCH: imem_req=1, imem_addr=pc, nop=1. On imem_ready=1: instr<=imem_rdata, → EXEC. Otherwise stay; addr is held stable.
  - EXEC: nop=0; npc_op is sampled at the clock edge.
    - hold=1: stay in EXEC, nothing updates.
    - hold=0: pc<=next_pc, → FETCH.
- Minimum cost is 2 cycles per instruction (FETCH with ready=1 in the same cycle, then EXEC).
- next_pc by npc_op (encodings fixed):
  - PLUS4 (0): pc+4.
  - BRANCH (1): pc+4 + (sign_ext(instr[15:0])<<2). Control has already folded Zero into the op.
  - JUMP (2): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - JR (3): jr_target.
  - EXCEPT (4): EXC_VECTOR.
  - Codes 5–7: treated as EXCEPT.
- Misaligned JR (jr_target[1:0]≠0): treated as EXCEPT.
- On any EXCEPT commit: epc<=pc, except_taken=1 for exactly the following cycle (registered pulse). epc is otherwise unchanged.
- All PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, with no exception.
- Branch offset arithmetic is 32-bit two's complement.
- Reset asserted mid-FETCH: imem_req drops immediately; any late imem_ready is ignored until FETCH is re-entered.
- imem_ready asserted outside FETCH is ignored.
- Outputs pc, pc_plus4, instr, nop and imem_* are registered or derived only from state/pc. There is no combinational path from npc_op to any output, so there is no loop through control.

Decomposition:
- NPC_* encodings (PLUS4=0, BRANCH=1, JUMP=2, JR=3, EXCEPT=4) are shared with the control unit and live in ctrl_encode_def.v.
- IFU state encodings (IDLE/FETCH/EXEC) are added to the same file.
- One natural sub-module: mips_npc, purely combinational. Inputs: pc, instr, npc_op, jr_target. Outputs: next_pc, is_exc.
- The FSM, PC, IR and EPC registers stay in mips_ifu.

Test Plan:
- Reset release, imem_ready tied 1 → imem_addr=0x3000 at first FETCH. With npc_op=PLUS4, successive fetch addresses are 0x3000, 0x3004, 0x3008, and nop toggles 1,0 per instruction.
- Fetch at pc=0x3010, instr=0x1000FFFE, npc_op=BRANCH → next fetch address 0x300C. Repeat with instr imm=0x0004 → 0x3024.
- pc=0x3000, instr=0x0C000C40, npc_op=JUMP → 0x3100. With npc_op=JR and jr_target=0x3200 → 0x3200. With jr_target=0x3202 → 0x4180, epc=0x3000, except_taken pulses 1 cycle.
- imem_ready held low 5 cycles in FETCH → imem_req and imem_addr stable, nop=1 throughout. Then ready=1 → instr latched, nop=0 next cycle. Also: hold=1 for 3 EXEC cycles → pc/instr unchanged, then advance.
- npc_op=6 at pc=0x3008 → pc=0x4180, epc=0x3008. Also: pc=0xFFFF_FFFC with PLUS4 → next fetch at 0x0000_0000.
- Assert rst while in FETCH with ready low → outputs immediately return to reset values. After release, the first fetch is at 0x3000 and the stale ready is ignored.
